// File: rtl/ascon_state_unloader.sv
// rtl/ascon_state_unloader.sv - captures a wide permutation state and streams it out word by word
module ascon_state_unloader #(
  parameter int STATE_W   = 320,
  parameter int WORD_W    = 32,
  parameter int MSW_FIRST = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               done_in,
  input  logic [STATE_W-1:0] state_in,
  output logic               o_valid,
  output logic [WORD_W-1:0]  o_data,
  output logic               o_last,
  input  logic               o_ready,
  output logic               busy,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam int NW = STATE_W / WORD_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  typedef enum logic {IDLE, STREAM} fsm_t;

  fsm_t               state_q, state_d;
  logic [STATE_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q;
  logic               overrun_q, overrun_d;

  logic cap;
  logic last_word;
  logic final_hs;

  // Only the rising edge of the completion level starts a capture.
  assign cap       = done_in && !done_q;
  assign last_word = (cnt_q == LAST_IDX);
  assign final_hs  = (state_q == STREAM) && o_ready && last_word;

  assign o_valid = (state_q == STREAM);
  assign busy    = (state_q == STREAM);
  assign o_last  = (state_q == STREAM) && last_word;
  assign o_data  = (MSW_FIRST != 0) ? shreg_q[STATE_W-1 -: WORD_W] : shreg_q[WORD_W-1:0];
  assign overrun = overrun_q;

  // State register, shift register, counter, edge detector and sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      done_q    <= done_in;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic: capture, shift on accept, back-to-back reload on the final word.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    overrun_d = clr_overrun ? 1'b0 : overrun_q;
    case (state_q)
      IDLE: begin
        if (cap) begin
          shreg_d = state_in;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (o_ready) begin
          if (last_word) begin
            cnt_d = '0;
            if (cap) begin
              shreg_d = state_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d = (MSW_FIRST != 0) ? (shreg_q << WORD_W) : (shreg_q >> WORD_W);
            cnt_d   = cnt_q + 1'b1;
          end
        end
        // A capture that cannot be taken is recorded; setting beats clearing.
        if (cap && !final_hs) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_state_unloader.sv
// tb/tb_ascon_state_unloader.sv - self-checking bench for ascon_state_unloader
module tb_ascon_state_unloader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         done_in = 1'b0;
  logic [319:0] state_in = '0;
  logic         o_ready = 1'b0;
  logic         clr_overrun = 1'b0;

  logic        m_valid, m_last, m_busy, m_ovr;
  logic [31:0] m_data;
  logic        l_valid, l_last, l_busy, l_ovr;
  logic [31:0] l_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ascon_state_unloader #(.STATE_W(320), .WORD_W(32), .MSW_FIRST(1)) u_msw (
    .clk(clk), .reset(reset), .done_in(done_in), .state_in(state_in),
    .o_valid(m_valid), .o_data(m_data), .o_last(m_last), .o_ready(o_ready),
    .busy(m_busy), .overrun(m_ovr), .clr_overrun(clr_overrun)
  );

  ascon_state_unloader #(.STATE_W(320), .WORD_W(32), .MSW_FIRST(0)) u_lsw (
    .clk(clk), .reset(reset), .done_in(done_in), .state_in(state_in),
    .o_valid(l_valid), .o_data(l_data), .o_last(l_last), .o_ready(o_ready),
    .busy(l_busy), .overrun(l_ovr), .clr_overrun(clr_overrun)
  );

  // Reference model: a queue of the words still owed downstream.
  typedef struct packed {
    logic [31:0] msw;
    logic [31:0] lsw;
    logic        last;
  } ent_t;

  ent_t exp_q[$];
  logic done_prev_m = 1'b0;
  logic ovr_m = 1'b0;

  typedef struct {
    logic        d;
    logic        r;
    logic        ev;
    logic [31:0] em;
    logic [31:0] el;
    logic        elast;
  } vec_t;

  vec_t tbl[11];

  localparam logic [319:0] V1 = 320'h80400c06_00000000_00010203_04050607_08090a0b_0c0d0e0f_00010203_04050607_08090a0b_0c0d0e0f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic check_model();
    logic v;
    v = (exp_q.size() > 0);
    chk("msw_valid", {31'b0, m_valid}, {31'b0, v});
    chk("lsw_valid", {31'b0, l_valid}, {31'b0, v});
    chk("msw_busy", {31'b0, m_busy}, {31'b0, v});
    chk("lsw_busy", {31'b0, l_busy}, {31'b0, v});
    chk("msw_overrun", {31'b0, m_ovr}, {31'b0, ovr_m});
    chk("lsw_overrun", {31'b0, l_ovr}, {31'b0, ovr_m});
    if (v) begin
      chk("msw_data", m_data, exp_q[0].msw);
      chk("lsw_data", l_data, exp_q[0].lsw);
      chk("msw_last", {31'b0, m_last}, {31'b0, exp_q[0].last});
      chk("lsw_last", {31'b0, l_last}, {31'b0, exp_q[0].last});
    end else begin
      chk("msw_last_idle", {31'b0, m_last}, 32'd0);
      chk("lsw_last_idle", {31'b0, l_last}, 32'd0);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic d, input logic [319:0] s, input logic r, input logic c);
    logic cap, hs, fin, was_empty, ovr_set;
    done_in     = d;
    state_in    = s;
    o_ready     = r;
    clr_overrun = c;
    cap       = d && !done_prev_m;
    was_empty = (exp_q.size() == 0);
    hs        = r && !was_empty;
    fin       = hs && (exp_q.size() == 1);
    ovr_set   = 1'b0;
    if (hs) void'(exp_q.pop_front());
    if (cap) begin
      if (was_empty || fin) begin
        for (int k = 0; k < 10; k++)
          exp_q.push_back('{msw: s[(9-k)*32 +: 32], lsw: s[k*32 +: 32], last: (k == 9)});
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (c) ovr_m = 1'b0;
    if (ovr_set) ovr_m = 1'b1;
    done_prev_m = d;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic drain(input bit rnd_ready);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      cycle(1'b0, rand_state(), rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", {31'b0, (exp_q.size() > 0)}, 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    done_in = 1'b0;
    o_ready = 1'b0;
    clr_overrun = 1'b0;
    #1;
    chk("rst_msw_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_lsw_valid", {31'b0, l_valid}, 32'd0);
    chk("rst_msw_last", {31'b0, m_last}, 32'd0);
    chk("rst_busy", {30'b0, m_busy, l_busy}, 32'd0);
    chk("rst_overrun", {30'b0, m_ovr, l_ovr}, 32'd0);
    chk("rst_msw_data", m_data, 32'd0);
    chk("rst_lsw_data", l_data, 32'd0);
    repeat (n) @(negedge clk);
    exp_q.delete();
    done_prev_m = 1'b0;
    ovr_m = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] mw[10];
    logic [31:0] lw[10];
    logic [319:0] va, vb;

    mw = '{32'h80400c06, 32'h00000000, 32'h00010203, 32'h04050607, 32'h08090a0b,
           32'h0c0d0e0f, 32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    lw = '{32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203, 32'h0c0d0e0f,
           32'h08090a0b, 32'h04050607, 32'h00010203, 32'h00000000, 32'h80400c06};
    for (int i = 0; i < 10; i++)
      tbl[i] = '{d: (i == 0), r: 1'b1, ev: 1'b1, em: mw[i], el: lw[i], elast: (i == 9)};
    tbl[10] = '{d: 1'b0, r: 1'b1, ev: 1'b0, em: 32'd0, el: 32'd0, elast: 1'b0};

    // Test 1: reset, then full-throughput stream of the reference vector.
    @(negedge clk);
    do_reset(4);
    @(negedge clk);
    check_model();
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].d, V1, tbl[i].r, 1'b0);
      chk("tbl_valid", {31'b0, m_valid}, {31'b0, tbl[i].ev});
      chk("tbl_valid_lsw", {31'b0, l_valid}, {31'b0, tbl[i].ev});
      chk("tbl_busy", {31'b0, m_busy}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk("tbl_msw_data", m_data, tbl[i].em);
        chk("tbl_lsw_data", l_data, tbl[i].el);
        chk("tbl_last", {31'b0, m_last}, {31'b0, tbl[i].elast});
      end
    end

    // Test 2: same vector under random backpressure.
    cycle(1'b1, V1, 1'($urandom_range(0, 1)), 1'b0);
    drain(1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Test 3: done held high for 30 cycles yields a single stream.
    for (int i = 0; i < 30; i++) cycle(1'b1, V1, 1'b1, 1'b0);
    chk("held_overrun", {31'b0, m_ovr}, 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Test 4: rising edge at word 4 is dropped and flagged, then cleared.
    va = rand_state();
    vb = rand_state();
    cycle(1'b1, va, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("ovr_word_idx4", m_data, va[319-128 -: 32]);
    cycle(1'b1, vb, 1'b1, 1'b0);
    chk("ovr_set", {31'b0, m_ovr}, 32'd1);
    drain(1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("ovr_sticky", {31'b0, m_ovr}, 32'd1);
    chk("ovr_no_second", {31'b0, m_valid}, 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("ovr_cleared", {31'b0, m_ovr}, 32'd0);

    // Test 5: new capture coincident with the accepted last word.
    va = rand_state();
    vb = rand_state();
    cycle(1'b1, va, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("b2b_last_before", {31'b0, m_last}, 32'd1);
    cycle(1'b1, vb, 1'b1, 1'b0);
    chk("b2b_valid", {31'b0, m_valid}, 32'd1);
    chk("b2b_word0", m_data, vb[319:288]);
    chk("b2b_word0_lsw", l_data, vb[31:0]);
    chk("b2b_overrun", {31'b0, m_ovr}, 32'd0);
    drain(1'b0);

    // Test 6: reset in the middle of a stream.
    cycle(1'b1, V1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("mid_word6_lsw", l_data, 32'h04050607);
    do_reset(2);
    for (int i = 0; i < 5; i++) cycle(1'b0, rand_state(), 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 7) == 0) ? 1'b1 : done_in & 1'($urandom_range(0, 1)),
            rand_state(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    drain(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_state_unloader.md
Name: ascon_state_unloader

Overview:
- Read-side companion of the Ascon permutation FSM.
- Captures the 320-bit permutation result when the FSM signals completion, then streams it out as 32-bit words over a valid/ready handshake.
- Sits between the permutation core and the narrow output bus or host interface, so the wide state never crosses a chip or IP boundary in parallel.

Parameters:
STATE_W, 320, width of permutation state; must be an integer multiple of WORD_W.
WORD_W, 32, output word width.
MSW_FIRST, 1, 1 = most-significant word first (state[319:288] first); 0 = least-significant word first.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
done_in  input  1  completion level from permutation FSM; may be held high for several cycles
state_in  input  STATE_W  permutation output; valid whenever done_in is high
o_valid  output  1  output word valid
o_data  output  WORD_W  current output word
o_last  output  1  high with the final word of a state (word index NW-1)
o_ready  input  1  downstream accepts word when o_valid && o_ready
busy  output  1  high while a captured state is being streamed
overrun  output  1  sticky: a new done rising edge arrived while busy and could not be captured
clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- NW = STATE_W/WORD_W (10 by default). Word counter is $clog2(NW) bits wide and never exceeds NW-1.
- Reset (reset = 0, asynchronous):
  - o_valid, o_last, busy, overrun = 0; o_data = 0.
  - Shift register, counter and done_q = 0; FSM = IDLE.
  - Reset asserted mid-stream drops the remaining words immediately; nothing resumes after release.
- Edge detect: done_q <= done_in each cycle; capture event cap = done_in && !done_q. A held-high done_in yields exactly one capture.
- FSM IDLE:
  - busy = 0, o_valid = 0.
  - On cap: load shift register with state_in, cnt <= 0, go to STREAM.
  - o_valid rises the cycle after the done_in rising edge (latency 1), with word 0 on o_data.
- FSM STREAM:
  - o_valid = 1, busy = 1.
  - o_data = top WORD_W bits of the shift register (MSW_FIRST = 1) or bottom WORD_W bits (MSW_FIRST = 0).
  - o_last = (cnt == NW-1).
- Handshake:
  - On o_valid && o_ready: shift by WORD_W toward the output end, cnt <= cnt + 1.
  - If cnt == NW-1: return to IDLE and o_valid falls next cycle.
  - With o_ready = 0, o_data, o_last and cnt hold stable; o_valid never drops before acceptance.
- Full throughput: with o_ready tied high, one word per cycle; NW cycles of o_valid per state.
- Simultaneous final handshake (cnt == NW-1) and cap: new state captured, cnt <= 0, stay in STREAM. Word 0 of the new state appears the next cycle with no bubble and no overrun.
- cap while in STREAM and not on the final handshake:
  - Capture ignored, current stream continues unaffected.
  - overrun <= 1 (sticky).
- clr_overrun: overrun <= 0 next cycle. If set and clear occur in the same cycle, set wins.
- Value on state_in while done_in is low is don't-care (X-tolerant); it is never sampled.

Test Plan:
1. Reset low 4 cycles, then done_in = 1 with state_in = 80400c06_00000000_00010203_04050607_08090a0b_0c0d0e0f_00010203_04050607_08090a0b_0c0d0e0f, o_ready = 1 -> o_valid rises 1 cycle later; 10 consecutive words 0x80400c06, 0x00000000, 0x00010203, ..., 0x0c0d0e0f; o_last only on 0x0c0d0e0f; busy falls after it.
2. Same stimulus, o_ready toggled 1,0,0,1,... (random backpressure) -> identical 10-word sequence; o_data stable while o_valid && !o_ready; no word duplicated or lost.
3. done_in held high 30 cycles -> exactly one 10-word stream; overrun stays 0.
4. Second done rising edge at word index 4, then clr_overrun pulse -> first stream completes unchanged; second state not emitted; overrun = 1 until the cycle after clr_overrun.
5. Second done rising edge coincident with the accepted o_last word -> next cycle o_valid = 1 with word 0 of the second state; overrun = 0; 20 words total, no gap.
6. MSW_FIRST = 0, test-1 vector; and separately reset asserted at word 6 -> LSW-first order: 0x0c0d0e0f, 0x08090a0b, ..., 0x80400c06; on reset all outputs are 0 immediately, and after release the block waits in IDLE with no residual words.
